// File: rtl/fifoctrl_pkg.sv
// Shared defaults for the single-clock FIFO pointer/flag controller.
// Holds the address-width and threshold defaults, the error-counter width and a saturating increment helper.
package fifoctrl_pkg;

  localparam int ADDRBIT_DEF   = 5;
  localparam int DEPTH_DEF     = 2 ** ADDRBIT_DEF;
  localparam int AFULL_TH_DEF  = DEPTH_DEF - 2;
  localparam int AEMPTY_TH_DEF = 2;
  localparam int ERRCNT_W      = 8;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    logic [ERRCNT_W-1:0] r;
    if (v == {ERRCNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: ADDRBIT address bits plus one wrap bit.
// Increments on inc, clears on flush; ptr_next is exported so flags can be computed from it.
module fifo_ptr
  import fifoctrl_pkg::*;
#(
  parameter int ADDRBIT = ADDRBIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inc,
  output logic [ADDRBIT:0] ptr,
  output logic [ADDRBIT:0] ptr_next
);

  logic [ADDRBIT:0] ptr_r;
  logic [ADDRBIT:0] ptr_next_s;

  // Next pointer: flush wins, otherwise natural binary increment carries into the wrap bit.
  always_comb begin
    ptr_next_s = ptr_r;
    if (flush) begin
      ptr_next_s = {(ADDRBIT+1){1'b0}};
    end else if (inc) begin
      ptr_next_s = ptr_r + {{ADDRBIT{1'b0}}, 1'b1};
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {(ADDRBIT+1){1'b0}};
    end else begin
      ptr_r <= ptr_next_s;
    end
  end

  assign ptr      = ptr_r;
  assign ptr_next = ptr_next_s;

endmodule

// File: rtl/fifoctrl_sync.sv
// Single-clock FIFO pointer/flag controller driving an external dual-port RAM (all 2**ADDRBIT slots usable).
// Define FIFOCTRL_ERRCNT_EN to add saturating rejected-push/pop counters ovf_cnt/udf_cnt.
module fifoctrl_sync
  import fifoctrl_pkg::*;
#(
  parameter int ADDRBIT   = ADDRBIT_DEF,
  parameter int AFULL_TH  = 2 ** ADDRBIT - 2,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               fifowr,
  input  logic               fiford,
  output logic               write,
  output logic [ADDRBIT-1:0] wraddr,
  output logic               read,
  output logic [ADDRBIT-1:0] rdaddr,
  output logic               fifofull,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [ADDRBIT:0]   fifolen,
`ifdef FIFOCTRL_ERRCNT_EN
  output logic [ERRCNT_W-1:0] ovf_cnt,
  output logic [ERRCNT_W-1:0] udf_cnt,
`endif
  output logic               overflow,
  output logic               underflow
);

  localparam logic [ADDRBIT:0] AFULL_TH_C  = AFULL_TH[ADDRBIT:0];
  localparam logic [ADDRBIT:0] AEMPTY_TH_C = AEMPTY_TH[ADDRBIT:0];

  logic             write_s;
  logic             read_s;
  logic [ADDRBIT:0] wptr_s;
  logic [ADDRBIT:0] wptr_next_s;
  logic [ADDRBIT:0] rptr_s;
  logic [ADDRBIT:0] rptr_next_s;
  logic             full_next_s;
  logic             empty_next_s;
  logic [ADDRBIT:0] len_next_s;
  logic             afull_next_s;
  logic             aempty_next_s;

  logic             full_r;
  logic             empty_r;
  logic             afull_r;
  logic             aempty_r;
  logic [ADDRBIT:0] len_r;
  logic             ovf_r;
  logic             udf_r;

  assign write_s = fifowr & ~full_r;
  assign read_s  = fiford & ~empty_r;

  fifo_ptr #(.ADDRBIT(ADDRBIT)) u_wptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .inc      (write_s),
    .ptr      (wptr_s),
    .ptr_next (wptr_next_s)
  );

  fifo_ptr #(.ADDRBIT(ADDRBIT)) u_rptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .inc      (read_s),
    .ptr      (rptr_s),
    .ptr_next (rptr_next_s)
  );

  // Flag and occupancy look-ahead from the next-state pointers.
  always_comb begin
    len_next_s    = wptr_next_s - rptr_next_s;
    empty_next_s  = (wptr_next_s == rptr_next_s);
    full_next_s   = (wptr_next_s[ADDRBIT] != rptr_next_s[ADDRBIT]) &&
                    (wptr_next_s[ADDRBIT-1:0] == rptr_next_s[ADDRBIT-1:0]);
    afull_next_s  = (len_next_s >= AFULL_TH_C);
    aempty_next_s = (len_next_s <= AEMPTY_TH_C);
  end

  // Registered status flags and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      len_r    <= {(ADDRBIT+1){1'b0}};
    end else if (flush) begin
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      len_r    <= {(ADDRBIT+1){1'b0}};
    end else begin
      full_r   <= full_next_s;
      empty_r  <= empty_next_s;
      afull_r  <= afull_next_s;
      aempty_r <= aempty_next_s;
      len_r    <= len_next_s;
    end
  end

  // Sticky error flags: a request arriving while the FIFO cannot honour it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (flush) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (fifowr & full_r);
      udf_r <= udf_r | (fiford & empty_r);
    end
  end

`ifdef FIFOCTRL_ERRCNT_EN
  logic [ERRCNT_W-1:0] ovf_cnt_r;
  logic [ERRCNT_W-1:0] udf_cnt_r;

  // Saturating counts of rejected pushes and pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_r <= {ERRCNT_W{1'b0}};
      udf_cnt_r <= {ERRCNT_W{1'b0}};
    end else if (flush) begin
      ovf_cnt_r <= {ERRCNT_W{1'b0}};
      udf_cnt_r <= {ERRCNT_W{1'b0}};
    end else begin
      ovf_cnt_r <= (fifowr & full_r)  ? sat_inc(ovf_cnt_r) : ovf_cnt_r;
      udf_cnt_r <= (fiford & empty_r) ? sat_inc(udf_cnt_r) : udf_cnt_r;
    end
  end

  assign ovf_cnt = ovf_cnt_r;
  assign udf_cnt = udf_cnt_r;
`endif

  assign write        = write_s;
  assign read         = read_s;
  assign wraddr       = wptr_s[ADDRBIT-1:0];
  assign rdaddr       = rptr_s[ADDRBIT-1:0];
  assign fifofull     = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign fifolen      = len_r;
  assign overflow     = ovf_r;
  assign underflow    = udf_r;

endmodule

// File: tb/tb_fifoctrl_sync.sv
// Scoreboard bench for fifoctrl_sync (ADDRBIT=3): the driver pushes per-cycle expectations from a
// queue-based occupancy model, a negedge monitor pops and compares them against the DUT outputs.
module tb_fifoctrl_sync;

  localparam int AB    = 3;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          fifowr = 1'b0;
  logic          fiford = 1'b0;
  logic          write;
  logic          read;
  logic [AB-1:0] wraddr;
  logic [AB-1:0] rdaddr;
  logic          fifofull;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AB:0]   fifolen;
  logic [7:0]    ovf_cnt;
  logic [7:0]    udf_cnt;
  logic          overflow;
  logic          underflow;

  fifoctrl_sync #(.ADDRBIT(AB), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifowr       (fifowr),
    .fiford       (fiford),
    .write        (write),
    .wraddr       (wraddr),
    .read         (read),
    .rdaddr       (rdaddr),
    .fifofull     (fifofull),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifolen      (fifolen),
`ifdef FIFOCTRL_ERRCNT_EN
    .ovf_cnt      (ovf_cnt),
    .udf_cnt      (udf_cnt),
`endif
    .overflow     (overflow),
    .underflow    (underflow)
  );

`ifndef FIFOCTRL_ERRCNT_EN
  assign ovf_cnt = 8'h00;
  assign udf_cnt = 8'h00;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int wr, rd, wa, ra, full, emp, af, ae, len, ovf, udf, ovc, udc;
  } exp_t;

  exp_t exp_q[$];

  // reference model state: stored item ids, running write/read counts, sticky flags
  int fifo_q[$];
  int wcnt, rcnt, m_ovf, m_udf, m_ovc, m_udc;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    fifo_q.delete();
    wcnt = 0; rcnt = 0; m_ovf = 0; m_udf = 0; m_ovc = 0; m_udc = 0;
  endtask

  // expectation for the current inputs given the model state after the last edge
  task automatic push_exp();
    exp_t e;
    int n;
    n = fifo_q.size();
    e.wr   = (fifowr && n < DEPTH) ? 1 : 0;
    e.rd   = (fiford && n > 0) ? 1 : 0;
    e.wa   = wcnt % DEPTH;
    e.ra   = rcnt % DEPTH;
    e.full = (n == DEPTH) ? 1 : 0;
    e.emp  = (n == 0) ? 1 : 0;
    e.af   = (n >= AF_TH) ? 1 : 0;
    e.ae   = (n <= AE_TH) ? 1 : 0;
    e.len  = n;
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    e.ovc  = m_ovc;
    e.udc  = m_udc;
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    int n;
    n = fifo_q.size();
    if (flush) begin
      model_reset();
    end else begin
      if (fifowr && n == DEPTH) begin
        m_ovf = 1;
        if (m_ovc < 255) m_ovc++;
      end
      if (fiford && n == 0) begin
        m_udf = 1;
        if (m_udc < 255) m_udc++;
      end
      if (fiford && n > 0) begin
        void'(fifo_q.pop_front());
        rcnt++;
      end
      if (fifowr && n < DEPTH) begin
        fifo_q.push_back(wcnt);
        wcnt++;
      end
    end
  endtask

  task automatic cycle(input logic wr, input logic rd, input logic fl);
    @(posedge clk);
    #1;
    fifowr = wr; fiford = rd; flush = fl;
    push_exp();
    model_step();
  endtask

  // asynchronous reset asserted between edges; monitor samples before the next edge
  task automatic do_reset();
    @(posedge clk);
    #1;
    fifowr = 1'b0; fiford = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    model_reset();
    push_exp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp();
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write",        int'(write),        e.wr);
        chk("read",         int'(read),         e.rd);
        chk("wraddr",       int'(wraddr),       e.wa);
        chk("rdaddr",       int'(rdaddr),       e.ra);
        chk("fifofull",     int'(fifofull),     e.full);
        chk("empty",        int'(empty),        e.emp);
        chk("almost_full",  int'(almost_full),  e.af);
        chk("almost_empty", int'(almost_empty), e.ae);
        chk("fifolen",      int'(fifolen),      e.len);
        chk("overflow",     int'(overflow),     e.ovf);
        chk("underflow",    int'(underflow),    e.udf);
`ifdef FIFOCTRL_ERRCNT_EN
        chk("ovf_cnt",      int'(ovf_cnt),      e.ovc);
        chk("udf_cnt",      int'(udf_cnt),      e.udc);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver
  initial begin
    int guard;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp();

    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
            ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 308; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifoctrl_sync.md
Name: fifoctrl_sync

Overview:
- Single-clock FIFO pointer/flag controller. Successor to the dual-clock-port controller.
- Drives an external dual-port RAM through write/wraddr and read/rdaddr.
- Generalised over address width, with programmable almost-full/almost-empty thresholds and an occupancy count.
- Uses all 2**ADDRBIT entries (no wasted slot), has sticky overflow/underflow flags and a synchronous flush. Sits between producer and consumer stages of the NTT/fqmul datapath.

Parameters:
- ADDRBIT, 5, RAM address width; DEPTH = 2**ADDRBIT entries.
- AFULL_TH, 2**ADDRBIT-2, almost_full asserts when count >= AFULL_TH (range 1..DEPTH).
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (range 0..DEPTH-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers and sticky flags.
- fifowr  in  1  push request.
- fiford  in  1  pop request.
- write  out  1  RAM write enable = fifowr & !fifofull (combinational).
- wraddr  out  ADDRBIT  RAM write address.
- read  out  1  RAM read enable = fiford & !empty (combinational).
- rdaddr  out  ADDRBIT  RAM read address.
- fifofull  out  1  registered full flag.
- empty  out  1  registered empty flag.
- almost_full  out  1  registered.
- almost_empty  out  1  registered.
- fifolen  out  ADDRBIT+1  registered occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Pointers
  - Internal wptr/rptr are ADDRBIT+1 bits; the MSB is the wrap bit.
  - wraddr = wptr[ADDRBIT-1:0], rdaddr = rptr[ADDRBIT-1:0].
  - Natural binary wrap DEPTH-1 -> 0 toggles the wrap bit. No hard-coded wrap constants.
- Reset (rst_n low, asynchronous)
  - Pointers = 0, fifolen = 0.
  - empty = 1, almost_empty = 1 (AEMPTY_TH >= 0).
  - fifofull = 0, almost_full = 0, overflow = 0, underflow = 0.
  - Reset mid-operation discards all contents immediately.
- Accepted operations
  - A push is accepted when write = 1: wptr increments next edge.
  - A pop is accepted when read = 1: rptr increments next edge.
- Flags
  - All flags are registered, computed from next-state pointers. They are valid the cycle after the operation, with zero extra latency versus pointer update.
  - empty_next = (wptr_next == rptr_next).
  - full_next = MSBs differ and lower ADDRBIT bits equal.
  - fifolen_next = wptr_next - rptr_next, modulo 2**(ADDRBIT+1).
  - almost_full/almost_empty are compared against fifolen_next.
- Simultaneous push and pop
  - Not full and not empty: both accepted, fifolen unchanged.
  - When full: pop accepted, push rejected (fifolen DEPTH -> DEPTH-1), overflow set.
  - When empty: push accepted, pop rejected (fifolen 0 -> 1), underflow set.
- Errors
  - overflow <= 1 on fifowr & fifofull.
  - underflow <= 1 on fiford & empty.
  - Both are sticky until flush or reset. Rejected requests do not move the pointers.
- Flush
  - Highest priority among synchronous events. On the next edge: pointers = 0, flags = their reset values, sticky flags cleared.
  - write/read are still combinationally asserted during the flush cycle; the RAM write is harmless because its data is discarded.
- Memory read latency belongs to the external RAM; this block makes no data-path timing promise.

Optional Feature:
- Macro FIFOCTRL_ERRCNT_EN.
- When defined:
  - Adds outputs ovf_cnt[7:0] and udf_cnt[7:0].
  - Each increments on every rejected push/pop respectively and saturates at 8'hFF.
  - Both clear on reset and on flush.
- When undefined: the ports and logic are absent; sticky overflow/underflow flags only.

Decomposition:
- Package fifoctrl_pkg: ADDRBIT default, derived DEPTH, threshold defaults, counter width constant (8).
- One natural sub-module, fifo_ptr: an (ADDRBIT+1)-bit pointer with increment enable and flush. Instantiated twice (write, read).
- Flag, count and error logic stay in the top.

Test Plan:
- ADDRBIT=3: reset, then 8 pushes -> fifolen 1..8, almost_full at count 6, fifofull after the 8th. The 9th push gives write=0, overflow=1, wraddr stays 0.
- From full: 8 pops -> rdaddr 0..7 then 0, empty=1 after the last, almost_empty at count 2. A 9th pop gives read=0, underflow=1.
- Count 4, fifowr=fiford=1 for 20 cycles -> fifolen stays 4, both pointers wrap through 7->0 twice, flags unchanged.
- Full, with simultaneous push+pop -> fifolen 7, fifofull=0, overflow=1. Empty, with simultaneous push+pop -> fifolen 1, empty=0, underflow=1.
- Count 5 with overflow set, assert flush together with fifowr -> next cycle fifolen 0, empty=1, overflow=0, pointers 0.
- rst_n low asynchronously mid-burst (between edges) -> outputs return to reset values before the next edge. With FIFOCTRL_ERRCNT_EN, 300 rejected pushes -> ovf_cnt = 8'hFF.
